// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - load/settle/run controller for the mips core
//
// Streams host program words into instruction memory, holds the core in reset
// while loading and for a settle window, releases it, then ends the run when
// the PC leaves the loaded image, on halt_req, or at an optional cycle limit.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   start         one-cycle pulse; begins a load from IDLE or DONE
//   load_valid    host word valid
//   load_data     host instruction word
//   load_last     final word of the program (qualified by load_valid)
//   load_ready    word accepted this cycle when high together with load_valid
//   halt_req      abort a load / stop a run
//   pc_in         core program counter
//   inst_we       core writeInst
//   inst_addr     core instAddress
//   inst_wdata    core inputInstruction
//   core_reset    core reset, active-high; low only while running
//   busy          LOAD, SETTLE or RUN
//   done          run finished; held until the next start
//   error         image truncated at MAX_WORDS; cleared by start
//   words_loaded  words written during the current load
//   state_o       IDLE=0 LOAD=1 SETTLE=2 RUN=3 DONE=4
module boot_sequencer #(
   parameter int          MAX_WORDS     = 64,
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int          SETTLE_CYCLES = 4,
   parameter int          RUN_LIMIT     = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           load_valid,
   input  logic [31:0]                    load_data,
   input  logic                           load_last,
   output logic                           load_ready,
   input  logic                           halt_req,
   input  logic [31:0]                    pc_in,
   output logic                           inst_we,
   output logic [31:0]                    inst_addr,
   output logic [31:0]                    inst_wdata,
   output logic                           core_reset,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded,
   output logic [2:0]                     state_o
);

   localparam int              WL_W       = $clog2(MAX_WORDS + 1);
   localparam int              SC_W       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [WL_W-1:0] LAST_IDX   = WL_W'(MAX_WORDS - 1);
   localparam logic [SC_W-1:0] SETTLE_END = SC_W'(SETTLE_CYCLES);
   localparam logic [31:0]     RUN_END    = 32'(RUN_LIMIT - 1);
   localparam bit              HAS_LIMIT  = (RUN_LIMIT != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state, state_d;
   logic [WL_W-1:0] wl_d;
   logic [SC_W-1:0] settle_cnt, settle_d;
   logic [31:0]     run_cnt, run_d;
   // Image length in bytes; the run ends when pc_in - BASE_ADDR reaches it.
   // A PC below BASE_ADDR wraps to a huge offset, so one unsigned compare
   // covers both ends of the image.
   logic [31:0]     img_bytes, img_d;
   logic            error_d;
   logic            we_d;
   logic [31:0]     addr_d, wdata_d;
   logic            hs;
   logic [31:0]     wr_addr;
   logic [31:0]     pc_off;

   assign state_o = state;

   always_comb begin
      state_d  = state;
      wl_d     = words_loaded;
      settle_d = settle_cnt;
      run_d    = run_cnt;
      img_d    = img_bytes;
      error_d  = error;

      hs      = load_valid && load_ready;
      wr_addr = BASE_ADDR + (32'(words_loaded) << 2);
      pc_off  = pc_in - BASE_ADDR;

      // Accepted word appears on the memory port one cycle later.
      we_d    = hs;
      addr_d  = hs ? wr_addr : inst_addr;
      wdata_d = hs ? load_data : inst_wdata;
      if (hs) begin
         wl_d = words_loaded + WL_W'(1);
      end

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               wl_d    = '0;
               error_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (halt_req) begin
               state_d = S_IDLE;
            end else if (hs && (load_last || words_loaded == LAST_IDX)) begin
               state_d  = S_SETTLE;
               settle_d = '0;
               img_d    = 32'(wl_d) << 2;
               if (!load_last) begin
                  error_d = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            // The first SETTLE cycle carries the final write and is not
            // counted, so core_reset stays high SETTLE_CYCLES full cycles
            // after it.
            if (halt_req) begin
               state_d = S_IDLE;
            end else if (settle_cnt == SETTLE_END) begin
               state_d = S_RUN;
               run_d   = '0;
            end else begin
               settle_d = settle_cnt + SC_W'(1);
            end
         end
         S_RUN: begin
            if (halt_req || (pc_off >= img_bytes) || (HAS_LIMIT && run_cnt == RUN_END)) begin
               state_d = S_DONE;
            end else begin
               run_d = run_cnt + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         words_loaded <= '0;
         settle_cnt   <= '0;
         run_cnt      <= '0;
         img_bytes    <= '0;
         error        <= 1'b0;
         inst_we      <= 1'b0;
         inst_addr    <= BASE_ADDR;
         inst_wdata   <= '0;
         load_ready   <= 1'b0;
         core_reset   <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         words_loaded <= wl_d;
         settle_cnt   <= settle_d;
         run_cnt      <= run_d;
         img_bytes    <= img_d;
         error        <= error_d;
         inst_we      <= we_d;
         inst_addr    <= addr_d;
         inst_wdata   <= wdata_d;
         load_ready   <= (state_d == S_LOAD);
         core_reset   <= (state_d != S_RUN);
         busy         <= (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
         done         <= (state_d == S_DONE);
      end
   end

endmodule
